// File: rtl/block_merger.sv
// Re-assembles a raster-order image from a block-order pixel stream and replays it over valid/ready.
// Optional macro BLOCK_MERGER_CHECK_EN cross-checks block_done strobes against the pixel count.
module block_merger #(
  parameter int Data_Depth = 8,
  parameter int Max_Dim    = 64,
  parameter int Addr_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            img_dim,
  input  logic [7:0]            blk_dim,
  input  logic [Data_Depth-1:0] Pixel_in,
  input  logic                  new_pixel,
  input  logic                  block_done,
  output logic [Data_Depth-1:0] pix_out,
  output logic                  pix_out_vld,
  input  logic                  pix_out_rdy,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err
);

  localparam int K_W   = Addr_W + 1;
  localparam int Depth = Max_Dim * Max_Dim;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            n_q, n_d;
  logic [7:0]            m_q, m_d;
  logic [7:0]            c_q, c_d;
  logic [7:0]            r_q, r_d;
  logic [7:0]            bcb_q, bcb_d;
  logic [7:0]            brb_q, brb_d;
  logic [K_W-1:0]        nn_q, nn_d;
  logic [K_W-1:0]        rd_k_q, rd_k_d;
  logic                  vld_q, vld_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [Data_Depth-1:0] pix_q;
  logic [Data_Depth-1:0] mem [0:Depth-1];

  logic                  cfg_bad_s;
  logic                  c_last_s;
  logic                  r_last_s;
  logic                  bc_last_s;
  logic                  br_last_s;
  logic                  pix_we_s;
  logic                  blk_end_s;
  logic                  frame_end_s;
  logic                  hs_s;
  logic                  load_s;
  logic [7:0]            c_nx_s;
  logic [7:0]            r_nx_s;
  logic [7:0]            bcb_nx_s;
  logic [7:0]            brb_nx_s;
  logic [Addr_W-1:0]     wr_addr_s;

`ifdef BLOCK_MERGER_CHECK_EN
  logic [1:0]            pend_q, pend_d;
  logic [7:0]            c_post_s;
  logic [7:0]            r_post_s;
`else
  logic                  unused_block_done_s;
  assign unused_block_done_s = block_done;
`endif

  // bcb/brb hold the pixel column/row of the current block's origin (bc*M, br*M)
  assign c_last_s    = (c_q == (m_q - 8'd1));
  assign r_last_s    = (r_q == (m_q - 8'd1));
  assign bc_last_s   = ((bcb_q + m_q) == n_q);
  assign br_last_s   = ((brb_q + m_q) == n_q);
  assign pix_we_s    = (state_q == COLLECT) && new_pixel;
  assign blk_end_s   = pix_we_s && c_last_s && r_last_s;
  assign frame_end_s = blk_end_s && bc_last_s && br_last_s;
  assign wr_addr_s   = (Addr_W'(brb_q) + Addr_W'(r_q)) * Addr_W'(n_q)
                     + Addr_W'(bcb_q) + Addr_W'(c_q);

  // Prefetch whenever the output slot is empty or being emptied this cycle
  assign hs_s   = vld_q && pix_out_rdy;
  assign load_s = (state_q == DRAIN) && (rd_k_q != nn_q) && (!vld_q || pix_out_rdy);

  assign pix_out     = pix_q;
  assign pix_out_vld = vld_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign err         = err_q;

  // Configuration legality; the modulo is only evaluated once blk_dim is known non-zero
  always_comb begin
    cfg_bad_s = 1'b0;
    if ((img_dim == 8'd0) || (blk_dim == 8'd0)) begin
      cfg_bad_s = 1'b1;
    end else if (32'(img_dim) > 32'(Max_Dim)) begin
      cfg_bad_s = 1'b1;
    end else begin
      cfg_bad_s = ((img_dim % blk_dim) != 8'd0);
    end
  end

  // Nested pixel -> row -> block-column -> block-row counter advance
  always_comb begin
    c_nx_s   = c_q + 8'd1;
    r_nx_s   = r_q;
    bcb_nx_s = bcb_q;
    brb_nx_s = brb_q;
    if (c_last_s) begin
      c_nx_s = 8'd0;
      if (r_last_s) begin
        r_nx_s = 8'd0;
        if (bc_last_s) begin
          bcb_nx_s = 8'd0;
          if (br_last_s) begin
            brb_nx_s = 8'd0;
          end else begin
            brb_nx_s = brb_q + m_q;
          end
        end else begin
          bcb_nx_s = bcb_q + m_q;
        end
      end else begin
        r_nx_s = r_q + 8'd1;
      end
    end else begin
      c_nx_s = c_q + 8'd1;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    c_d     = c_q;
    r_d     = r_q;
    bcb_d   = bcb_q;
    brb_d   = brb_q;
    nn_d    = nn_q;
    rd_k_d  = rd_k_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef BLOCK_MERGER_CHECK_EN
    pend_d   = pend_q;
    c_post_s = pix_we_s ? c_nx_s : c_q;
    r_post_s = pix_we_s ? r_nx_s : r_q;
    // Evaluated after this cycle's pixel is counted; a start below overrides it
    err_d = err_d | (block_done && ((c_post_s != 8'd0) || (r_post_s != 8'd0)));
    if (blk_end_s && !block_done) begin
      pend_d = 2'd2;
    end else if (pend_q == 2'd0) begin
      pend_d = 2'd0;
    end else if (block_done) begin
      pend_d = 2'd0;
    end else if (pend_q == 2'd1) begin
      pend_d = 2'd0;
      err_d  = 1'b1;
    end else begin
      pend_d = pend_q - 2'd1;
    end
`endif
    case (state_q)
      IDLE: begin
        if (start && cfg_bad_s) begin
          err_d = 1'b1;
        end else if (start) begin
          n_d     = img_dim;
          m_d     = blk_dim;
          c_d     = 8'd0;
          r_d     = 8'd0;
          bcb_d   = 8'd0;
          brb_d   = 8'd0;
          rd_k_d  = '0;
          nn_d    = K_W'(img_dim) * K_W'(img_dim);
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = COLLECT;
`ifdef BLOCK_MERGER_CHECK_EN
          pend_d  = 2'd0;
`endif
        end else if (new_pixel) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (pix_we_s) begin
          c_d   = c_nx_s;
          r_d   = r_nx_s;
          bcb_d = bcb_nx_s;
          brb_d = brb_nx_s;
          if (frame_end_s) begin
            state_d = DRAIN;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      DRAIN: begin
        err_d = err_d | new_pixel;
        if (load_s) begin
          vld_d  = 1'b1;
          rd_k_d = rd_k_q + K_W'(1);
        end else if (hs_s) begin
          // load_s is false with rdy high only once every pixel has been fetched
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          vld_d = vld_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= 8'd0;
      m_q     <= 8'd0;
      c_q     <= 8'd0;
      r_q     <= 8'd0;
      bcb_q   <= 8'd0;
      brb_q   <= 8'd0;
      nn_q    <= '0;
      rd_k_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BLOCK_MERGER_CHECK_EN
      pend_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      c_q     <= c_d;
      r_q     <= r_d;
      bcb_q   <= bcb_d;
      brb_q   <= brb_d;
      nn_q    <= nn_d;
      rd_k_q  <= rd_k_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef BLOCK_MERGER_CHECK_EN
      pend_q  <= pend_d;
`endif
    end
  end

  // Frame buffer write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (pix_we_s) begin
      mem[wr_addr_s] <= Pixel_in;
    end
  end

  // Synchronous read port doubles as the output register, so pix_out holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= '0;
    end else if (load_s) begin
      pix_q <= mem[rd_k_q[Addr_W-1:0]];
    end else begin
      pix_q <= pix_q;
    end
  end

endmodule
